// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch vectors, the canonical NOP and
// the next-PC source encoding used by the fetch stage and hazard unit.
package mips_pkg;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC   = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_EXC,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_IRQ,
        SEL_HOLD,
        SEL_SEQ
    } pc_sel_t;

    // Bit 31 is the supervisor bit; the increment wraps inside bits 30:0 only.
    function automatic logic [31:0] pc_inc4(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and flush controls.
// A flush inserts a bubble whose instruction is the architectural NOP.
module if_id_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr,
    input  logic [31:0] pc_plus4,
    output logic [31:0] instr_r,
    output logic [31:0] pc_plus4_r,
    output logic        valid_r
);
    import mips_pkg::*;

    // Flush wins over load; neither asserted means hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_r    <= NOP_INSTR;
            pc_plus4_r <= 32'h0000_0000;
            valid_r    <= 1'b0;
        end else if (flush) begin
            instr_r    <= NOP_INSTR;
            pc_plus4_r <= 32'h0000_0000;
            valid_r    <= 1'b0;
        end else if (load) begin
            instr_r    <= instr;
            pc_plus4_r <= pc_plus4;
            valid_r    <= 1'b1;
        end else begin
            instr_r    <= instr_r;
            pc_plus4_r <= pc_plus4_r;
            valid_r    <= valid_r;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, prioritised next-PC selection,
// IF/ID capture and EPC generation for interrupts and exceptions.
module if_fetch_stage #(
    parameter logic [31:0] RESET_VEC = mips_pkg::RESET_VEC,
    parameter logic [31:0] IRQ_VEC   = mips_pkg::IRQ_VEC,
    parameter logic [31:0] EXC_VEC   = mips_pkg::EXC_VEC
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        exc_i,
    input  logic        irq_i,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc_plus4_o,
    output logic        ifid_valid_o,
    output logic [31:0] epc_o,
    output logic        epc_we_o,
    output logic        kernel_o
);
    import mips_pkg::*;

    logic [31:0] pc_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] pc_next_s;
    logic [31:0] epc_r;
    logic [31:0] epc_next_s;
    logic        epc_we_r;
    logic        epc_we_next_s;
    logic        irq_take_s;
    logic        ifid_load_s;
    logic        ifid_flush_s;
    pc_sel_t     sel_s;

    assign pc_plus4_s = pc_inc4(pc_r);
    // Interrupts are masked in kernel mode and yield to every other event.
    assign irq_take_s = irq_i & ~pc_r[31] & ~exc_i & ~branch_i & ~jump_i & ~stall_i;

    // Priority select of the next-PC source.
    always_comb begin
        sel_s = SEL_SEQ;
        if (exc_i) begin
            sel_s = SEL_EXC;
        end else if (branch_i) begin
            sel_s = SEL_BRANCH;
        end else if (jump_i) begin
            sel_s = SEL_JUMP;
        end else if (irq_take_s) begin
            sel_s = SEL_IRQ;
        end else if (stall_i) begin
            sel_s = SEL_HOLD;
        end else begin
            sel_s = SEL_SEQ;
        end
    end

    // Decode the selected source into PC, IF/ID and EPC controls.
    always_comb begin
        pc_next_s     = pc_r;
        ifid_load_s   = 1'b0;
        ifid_flush_s  = 1'b0;
        epc_next_s    = epc_r;
        epc_we_next_s = 1'b0;
        case (sel_s)
            SEL_EXC: begin
                pc_next_s     = EXC_VEC;
                ifid_flush_s  = 1'b1;
                epc_next_s    = ifid_pc_plus4_o;
                epc_we_next_s = 1'b1;
            end
            SEL_BRANCH: begin
                pc_next_s    = branch_target_i;
                ifid_flush_s = 1'b1;
            end
            SEL_JUMP: begin
                pc_next_s    = jump_target_i;
                ifid_flush_s = 1'b1;
            end
            SEL_IRQ: begin
                pc_next_s     = IRQ_VEC;
                ifid_flush_s  = 1'b1;
                epc_next_s    = pc_r;
                epc_we_next_s = 1'b1;
            end
            SEL_SEQ: begin
                pc_next_s   = pc_plus4_s;
                ifid_load_s = 1'b1;
            end
            SEL_HOLD: begin
                pc_next_s = pc_r;
            end
            default: begin
                pc_next_s = pc_r;
            end
        endcase
    end

    // PC and EPC state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r     <= RESET_VEC;
            epc_r    <= 32'h0000_0000;
            epc_we_r <= 1'b0;
        end else begin
            pc_r     <= pc_next_s;
            epc_r    <= epc_next_s;
            epc_we_r <= epc_we_next_s;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (ifid_load_s),
        .flush      (ifid_flush_s),
        .instr      (imem_instr),
        .pc_plus4   (pc_plus4_s),
        .instr_r    (ifid_instr_o),
        .pc_plus4_r (ifid_pc_plus4_o),
        .valid_r    (ifid_valid_o)
    );

    assign imem_addr = pc_r;
    assign epc_o     = epc_r;
    assign epc_we_o  = epc_we_r;
    assign kernel_o  = pc_r[31];

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios followed by
// randomized traffic, compared against a cycle-level behavioural model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall_i, jump_i, branch_i, exc_i, irq_i;
    logic [31:0] jump_target_i, branch_target_i;
    logic [31:0] ifid_instr_o, ifid_pc_plus4_o, epc_o;
    logic        ifid_valid_o, epc_we_o, kernel_o;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pc4, m_epc;
    logic        m_valid, m_we;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[30:2] == 29'd0) return 32'h0800_0003;
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    if_fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .stall_i         (stall_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .exc_i           (exc_i),
        .irq_i           (irq_i),
        .ifid_instr_o    (ifid_instr_o),
        .ifid_pc_plus4_o (ifid_pc_plus4_o),
        .ifid_valid_o    (ifid_valid_o),
        .epc_o           (epc_o),
        .epc_we_o        (epc_we_o),
        .kernel_o        (kernel_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h8000_0000; m_instr = 32'h0; m_pc4 = 32'h0;
        m_valid = 1'b0; m_epc = 32'h0; m_we = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".pc"},     imem_addr, m_pc);
        check_eq({tag, ".kernel"}, {31'd0, kernel_o}, {31'd0, m_pc[31]});
        check_eq({tag, ".valid"},  {31'd0, ifid_valid_o}, {31'd0, m_valid});
        check_eq({tag, ".instr"},  ifid_instr_o, m_instr);
        if (m_valid) check_eq({tag, ".pc4"}, ifid_pc_plus4_o, m_pc4);
        check_eq({tag, ".epc"},    epc_o, m_epc);
        check_eq({tag, ".epc_we"}, {31'd0, epc_we_o}, {31'd0, m_we});
    endtask

    task automatic idle();
        stall_i = 1'b0; jump_i = 1'b0; branch_i = 1'b0; exc_i = 1'b0; irq_i = 1'b0;
        jump_target_i = 32'h0; branch_target_i = 32'h0;
    endtask

    // One clock: predict from the rules, advance, then compare.
    task automatic step(input string tag);
        logic [31:0] p4, npc, ni, np4, nepc;
        logic        nv, nwe;
        p4   = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
        npc  = p4; ni = mem_word(m_pc); np4 = p4; nv = 1'b1;
        nepc = m_epc; nwe = 1'b0;
        if (exc_i) begin
            npc = 32'h8000_0008; ni = 32'h0; np4 = 32'h0; nv = 1'b0;
            nepc = m_pc4; nwe = 1'b1;
        end else if (branch_i) begin
            npc = branch_target_i; ni = 32'h0; np4 = 32'h0; nv = 1'b0;
        end else if (jump_i) begin
            npc = jump_target_i; ni = 32'h0; np4 = 32'h0; nv = 1'b0;
        end else if (irq_i && !m_pc[31] && !stall_i) begin
            npc = 32'h8000_0004; ni = 32'h0; np4 = 32'h0; nv = 1'b0;
            nepc = m_pc; nwe = 1'b1;
        end else if (stall_i) begin
            npc = m_pc; ni = m_instr; np4 = m_pc4; nv = m_valid;
        end
        @(posedge clk);
        #1;
        m_pc = npc; m_instr = ni; m_pc4 = np4; m_valid = nv; m_epc = nepc; m_we = nwe;
        check_all(tag);
    endtask

    task automatic jump_to(input logic [31:0] t);
        idle(); jump_i = 1'b1; jump_target_i = t;
        step("jmp");
        idle();
    endtask

    initial begin
        logic [31:0] hold_instr, hold_pc4;
        idle();
        reset = 1'b1;
        model_reset();
        #12;
        check_all("reset");
        reset = 1'b0;

        // 1: first fetch from the reset vector
        step("t1");
        check_eq("t1.instr_const", ifid_instr_o, 32'h0800_0003);
        check_eq("t1.pc4_const", ifid_pc_plus4_o, 32'h8000_0004);

        // 2: jump while PC = 80000004
        check_eq("t2.pc_before", imem_addr, 32'h8000_0004);
        jump_i = 1'b1; jump_target_i = 32'h8000_000C;
        step("t2");
        check_eq("t2.pc_const", imem_addr, 32'h8000_000C);
        idle();
        step("t2b");

        // 3: three-cycle stall at PC = 0x30
        jump_to(32'h0000_002C);
        step("t3pre");
        hold_instr = ifid_instr_o; hold_pc4 = ifid_pc_plus4_o;
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("t3stall");
            check_eq("t3.pc_hold", imem_addr, 32'h0000_0030);
            check_eq("t3.instr_hold", ifid_instr_o, hold_instr);
            check_eq("t3.pc4_hold", ifid_pc_plus4_o, hold_pc4);
        end
        stall_i = 1'b0;
        step("t3rel");
        check_eq("t3.advance", imem_addr, 32'h0000_0034);

        // 4: interrupt accepted in user mode, ignored in kernel mode
        jump_to(32'h0000_005C);
        irq_i = 1'b1;
        step("t4");
        check_eq("t4.pc_const", imem_addr, 32'h8000_0004);
        check_eq("t4.epc_const", epc_o, 32'h0000_005C);
        check_eq("t4.we_const", {31'd0, epc_we_o}, 32'd1);
        step("t4k1");
        check_eq("t4.no_reaccept", {31'd0, epc_we_o}, 32'd0);
        step("t4k2");
        irq_i = 1'b0;

        // 5: branch beats jump and stall
        branch_i = 1'b1; branch_target_i = 32'h0000_0040;
        jump_i = 1'b1; jump_target_i = 32'h0000_0100; stall_i = 1'b1;
        step("t5");
        check_eq("t5.pc_const", imem_addr, 32'h0000_0040);
        idle();

        // 6: exception beats a pending interrupt
        jump_to(32'h0000_0014);
        step("t6pre");
        check_eq("t6.pc4_before", ifid_pc_plus4_o, 32'h0000_0018);
        exc_i = 1'b1; irq_i = 1'b1;
        step("t6");
        check_eq("t6.pc_const", imem_addr, 32'h8000_0008);
        check_eq("t6.epc_const", epc_o, 32'h0000_0018);
        idle();

        // PC wrap keeps the supervisor bit clear
        jump_to(32'h7FFF_FFFC);
        step("wrap");
        check_eq("wrap.pc_const", imem_addr, 32'h0000_0000);

        // Asynchronous reset between edges
        step("pre_arst");
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_all("arst");
        #2 reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            exc_i    = ($urandom_range(0, 19) == 0);
            branch_i = ($urandom_range(0, 9) == 0);
            jump_i   = ($urandom_range(0, 7) == 0);
            stall_i  = ($urandom_range(0, 5) == 0);
            irq_i    = ($urandom_range(0, 2) == 0);
            jump_target_i   = {($urandom_range(0, 9) < 3), $urandom_range(0, 32'h1FFF_FFFF), 2'b00};
            branch_target_i = {($urandom_range(0, 9) < 3), $urandom_range(0, 32'h1FFF_FFFF), 2'b00};
            step("rnd");
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
